// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the single register-file write port.
// Port A (ALU) normally wins; port B (load unit) is guaranteed a grant after
// STARVE_MAX consecutive lost arbitrations. The winning write is registered,
// writes to x0 are accepted but not performed, and the registered write is
// exposed as a bypass for same-cycle reads.
//
// Handshake: a transfer on port x happens at a rising clk edge where
// x_valid && x_ready. Requesters hold valid/rd/data stable until accepted.
// x_ready depends only on the two valids and the starvation counter, never on
// rd or data. At most one ready is high per cycle. Both readies are low while
// rst_n is low.
module regfile_wb_arbiter #(
  parameter int XLEN       = 32,
  parameter int AW         = 5,
  parameter int STARVE_MAX = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            a_valid,
  input  logic [AW-1:0]   a_rd,
  input  logic [XLEN-1:0] a_data,
  output logic            a_ready,
  input  logic            b_valid,
  input  logic [AW-1:0]   b_rd,
  input  logic [XLEN-1:0] b_data,
  output logic            b_ready,
  output logic            rf_we,
  output logic [AW-1:0]   rf_wa,
  output logic [XLEN-1:0] rf_wd,
  output logic            byp_valid,
  output logic [AW-1:0]   byp_rd,
  output logic [XLEN-1:0] byp_data
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  logic [CW-1:0]   starve_q, starve_d;
  logic            we_q, we_d;
  logic [AW-1:0]   wa_q, wa_d;
  logic [XLEN-1:0] wd_q, wd_d;
  logic            grant_a, grant_b;
  logic [AW-1:0]   win_rd;
  logic [XLEN-1:0] win_data;

  // Grant decision: B wins when A is idle or B has lost STARVE_MAX times.
  // Readies are masked by rst_n so nothing is offered while in reset.
  always_comb begin
    grant_b = 1'b0;
    grant_a = 1'b0;
    if (rst_n) begin
      grant_b = b_valid && ((starve_q == STARVE_LIM) || !a_valid);
      grant_a = a_valid && !grant_b;
    end
    a_ready = grant_a;
    b_ready = grant_b;
  end

  // Winner mux plus next-state for the starvation counter and output register.
  always_comb begin
    win_rd   = grant_b ? b_rd   : a_rd;
    win_data = grant_b ? b_data : a_data;
    starve_d = starve_q;
    we_d     = 1'b0;
    wa_d     = wa_q;
    wd_d     = wd_q;
    if (!b_valid || grant_b) begin
      starve_d = '0;
    end else if (grant_a && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + 1'b1;
    end
    if (grant_a || grant_b) begin
      wa_d = win_rd;
      wd_d = win_data;
      we_d = (win_rd != '0);
    end
  end

  // State registers; asynchronous reset drops any pending write at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
      we_q     <= 1'b0;
      wa_q     <= '0;
      wd_q     <= '0;
    end else begin
      starve_q <= starve_d;
      we_q     <= we_d;
      wa_q     <= wa_d;
      wd_q     <= wd_d;
    end
  end

  assign rf_we     = we_q;
  assign rf_wa     = wa_q;
  assign rf_wd     = wd_q;
  assign byp_valid = we_q;
  assign byp_rd    = wa_q;
  assign byp_data  = wd_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios followed by
// randomized traffic, all compared against a behavioural reference model.
module tb_regfile_wb_arbiter;

  localparam int XLEN       = 32;
  localparam int AW         = 5;
  localparam int STARVE_MAX = 3;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            a_valid = 1'b0, b_valid = 1'b0;
  logic [AW-1:0]   a_rd = '0, b_rd = '0;
  logic [XLEN-1:0] a_data = '0, b_data = '0;
  logic            a_ready, b_ready;
  logic            rf_we, byp_valid;
  logic [AW-1:0]   rf_wa, byp_rd;
  logic [XLEN-1:0] rf_wd, byp_data;

  regfile_wb_arbiter #(.XLEN(XLEN), .AW(AW), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .byp_valid(byp_valid), .byp_rd(byp_rd), .byp_data(byp_data)
  );

  // reference model state
  int                 starve;     // consecutive lost arbitrations of B
  logic               exp_we;
  logic [AW-1:0]      exp_wa;
  logic [XLEN-1:0]    exp_wd;
  logic [AW+XLEN-1:0] exp_q[$];   // writes expected to reach the register file

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    starve = 0;
    exp_we = 1'b0;
    exp_wa = '0;
    exp_wd = '0;
    exp_q.delete();
  endtask

  // One clock cycle: check readies mid-cycle, advance model at the edge,
  // check the registered write just after the edge.
  task automatic step(output bit ga, output bit gb);
    logic [AW-1:0]      rd;
    logic [XLEN-1:0]    data;
    logic [AW+XLEN-1:0] e;
    @(negedge clk);
    gb = b_valid && (starve >= STARVE_MAX || !a_valid);
    ga = a_valid && !gb;
    chk("a_ready", a_ready, ga);
    chk("b_ready", b_ready, gb);
    @(posedge clk);
    rd   = gb ? b_rd : a_rd;
    data = gb ? b_data : a_data;
    if (!b_valid || gb) starve = 0;
    else if (ga) starve = (starve + 1 > STARVE_MAX) ? STARVE_MAX : starve + 1;
    exp_we = (ga || gb) && (rd != 0);
    if (ga || gb) begin
      exp_wa = rd;
      exp_wd = data;
    end
    if (exp_we) exp_q.push_back({rd, data});
    #1;
    chk("rf_we", rf_we, exp_we);
    chk("rf_wa", rf_wa, exp_wa);
    chk("rf_wd", rf_wd, exp_wd);
    chk("byp", {byp_valid, byp_rd, byp_data}, {exp_we, exp_wa, exp_wd});
    if (rf_we) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_write", 1'b1, 1'b0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_write", {rf_wa, rf_wd}, e);
      end
    end
  endtask

  initial begin
    bit ga, gb;
    int nb;
    model_reset();

    // reset: both valid, nothing offered, outputs cleared
    a_valid = 1'b1; a_rd = 5'd1; a_data = 32'h1;
    b_valid = 1'b1; b_rd = 5'd2; b_data = 32'h2;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_a_ready", a_ready, 1'b0);
    chk("rst_b_ready", b_ready, 1'b0);
    chk("rst_out", {rf_we, rf_wa, rf_wd}, '0);
    chk("rst_byp", {byp_valid, byp_rd, byp_data}, '0);
    @(posedge clk); #1 rst_n = 1'b1;
    step(ga, gb);
    chk("first_grant_is_a", ga, 1'b1);
    b_valid = 1'b0; a_valid = 1'b0;
    step(ga, gb);

    // single write
    a_valid = 1'b1; a_rd = 5'd5; a_data = 32'hDEADBEEF;
    step(ga, gb);
    chk("single_rf_wd", rf_wd, 32'hDEADBEEF);
    a_valid = 1'b0;
    step(ga, gb);
    chk("single_we_drop", rf_we, 1'b0);

    // starvation: A,A,A,B repeating
    a_valid = 1'b1; b_valid = 1'b1; b_rd = 5'd7; b_data = 32'h11;
    for (int i = 0; i < 12; i++) begin
      a_rd = 5'($urandom_range(1, 31)); a_data = $urandom;
      if (a_rd == 5'd7) a_rd = 5'd8;
      step(ga, gb);
      chk("starve_pattern", gb, (i % 4) == 3);
    end
    a_valid = 1'b0; b_valid = 1'b0;
    step(ga, gb);

    // x0 drop then a normal write
    b_valid = 1'b1; b_rd = 5'd0; b_data = 32'hFFFFFFFF;
    step(ga, gb);
    chk("x0_no_we", rf_we, 1'b0);
    b_valid = 1'b0; a_valid = 1'b1; a_rd = 5'd3; a_data = $urandom;
    step(ga, gb);
    chk("after_x0_wa", {rf_we, rf_wa}, {1'b1, 5'd3});
    a_valid = 1'b0;

    // B-only stream, then idle hold
    b_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      b_rd = 5'($urandom_range(1, 31)); b_data = $urandom;
      step(ga, gb);
    end
    b_valid = 1'b0;
    step(ga, gb);
    step(ga, gb);
    // B granted every cycle above means its counter stayed clear: A,A,A,B again
    a_valid = 1'b1; b_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(ga, gb);
      chk("bonly_cnt_clear", gb, i == 3);
    end

    // async reset mid-stream with starve counter nonzero
    step(ga, gb);
    step(ga, gb);
    a_rd = 5'd9; a_data = $urandom;
    step(ga, gb);
    chk("pre_rst_we", rf_we, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_we", rf_we, 1'b0);
    chk("async_rst_byp", byp_valid, 1'b0);
    chk("async_rst_ready", {a_ready, b_ready}, 2'b00);
    model_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(ga, gb);
      chk("post_rst_cnt_clear", gb, i == 3);
    end
    a_valid = 1'b0; b_valid = 1'b0;

    // randomized traffic, requests held until accepted
    nb = 0;
    ga = 1'b1; gb = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (!a_valid || ga) begin
        a_valid = 1'($urandom_range(0, 1));
        a_rd = 5'($urandom_range(0, 31)); a_data = $urandom;
      end
      if (!b_valid || gb) begin
        b_valid = 1'($urandom_range(0, 3) != 0);
        b_rd = 5'($urandom_range(0, 31)); b_data = $urandom;
      end
      step(ga, gb);
      if (gb) nb++;
    end
    chk("rand_b_progress", nb > 0, 1'b1);
    chk("sb_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter for the single write port of the 32×32 integer register file. Two requesters share the port: the ALU result path (port A) and the load/multi-cycle unit (port B). The block grants one request per cycle using valid/ready handshakes, applies a starvation guard so B cannot be locked out, registers the winning write for the register file, drops writes to x0, and exposes that registered write as a bypass for same-cycle reads.

## Interface
Parameters:
- XLEN, 32, data width of a register write.
- AW, 5, register address width (rd).
- STARVE_MAX, 3, consecutive lost arbitrations after which B wins; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- a_valid  in  1  ALU write request.
- a_rd  in  AW  ALU destination register.
- a_data  in  XLEN  ALU write data.
- a_ready  out  1  A accepted this cycle (combinational).
- b_valid  in  1  load-unit write request.
- b_rd  in  AW  load destination register.
- b_data  in  XLEN  load write data.
- b_ready  out  1  B accepted this cycle (combinational).
- rf_we  out  1  register-file write enable.
- rf_wa  out  AW  register-file write address.
- rf_wd  out  XLEN  register-file write data.
- byp_valid  out  1  equal to rf_we; bypass is valid.
- byp_rd  out  AW  equal to rf_wa.
- byp_data  out  XLEN  equal to rf_wd.

## Operation
- A transfer occurs on a cycle where x_valid && x_ready at the clk rising edge.
- At most one of a_ready and b_ready is high in any cycle.
- Grant rule, evaluated each cycle:
  - B is granted if b_valid and (starve_cnt == STARVE_MAX or !a_valid).
  - Otherwise A is granted if a_valid.
  - Otherwise nothing is granted.
- x_ready depends only on x_valid, the other valid and starve_cnt; it never depends on data or rd.
- Requesters hold valid, rd and data stable until accepted. The arbiter does not check this.
- starve_cnt is an internal counter, width clog2(STARVE_MAX+1). Its next value is:
  - 0 if B is granted or b_valid is low;
  - min(starve_cnt+1, STARVE_MAX) if b_valid is high and A is granted.
- Output register, updated every cycle:
  - On any grant: rf_wa <= rd of the winner, rf_wd <= data of the winner.
  - rf_we <= 1 only if the winner's rd != 0.
  - With no grant: rf_we <= 0; rf_wa and rf_wd hold their previous values.
- x0 writes are accepted (ready asserted) and then discarded (rf_we stays 0). They do not affect starve_cnt differently from any other grant.
- Bypass outputs are wired to the output register. Read logic compares each source register against byp_rd when byp_valid is high, because the register-file write does not land until the next edge.

## Timing
- Reset (rst_n low, asynchronous):
  - rf_we=0, rf_wa=0, rf_wd=0, starve_cnt=0.
  - a_ready=0 and b_ready=0 while rst_n is low.
  - byp_* follow rf_*.
- First grant is possible in the first cycle after rst_n deasserts.
- Latency: request accepted at edge N → rf_we/rf_wa/rf_wd valid for exactly the cycle after edge N. The register file writes at edge N+1.
- Throughput: one write per cycle. Back-to-back grants produce back-to-back rf_we pulses with no bubble.
- Simultaneous A and B requests with starve_cnt < STARVE_MAX: A wins.
- Simultaneous A and B requests with starve_cnt == STARVE_MAX: B wins and starve_cnt returns to 0.
- Both requesters targeting the same rd: they are granted in separate cycles, so the later grant's data is what remains in the register.
- Reset asserted mid-transfer: the pending output write is lost (rf_we goes to 0 immediately) and starve_cnt clears. Requesters re-present after reset.
- No combinational path from any data or rd input to any ready output.

## Test plan
- Reset: hold rst_n=0 with a_valid=b_valid=1 → a_ready=b_ready=0 and rf_we=0. Release reset → A is granted on the first cycle.
- Single write: a_valid=1, a_rd=5, a_data=0xDEADBEEF for one cycle → a_ready=1. Next cycle rf_we=1, rf_wa=5, rf_wd=0xDEADBEEF, byp_* match. The cycle after, rf_we=0.
- Starvation with STARVE_MAX=3: hold a_valid and b_valid continuously (b_rd=7, b_data=0x11) with new A data each cycle → grant sequence A,A,A,B,A,A,A,B,…, and rf_wa=7 appears every 4th write cycle.
- x0 drop: b_valid=1, b_rd=0, b_data=0xFFFFFFFF → b_ready=1, next cycle rf_we=0. A following write with a_rd=3 produces rf_we=1, rf_wa=3.
- Idle and B-only: b_valid=1 with a_valid=0 → B is granted every cycle and starve_cnt stays 0. Drop b_valid → rf_we=0 and rf_wa/rf_wd hold.
- Async reset mid-stream: assert rst_n low between clock edges while rf_we=1 → rf_we falls immediately (before the next edge) and starve_cnt=0 after release.
